// File: rtl/rx_mass_checker_if.sv
// Stream bundle for rx_mass_checker: 8-bit RX byte stream in, 32-bit one-beat result stream out.
// The checker takes the slave modport; whatever feeds bytes and reads results takes master.
interface rx_mass_checker_if;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        o_err;

    modport slave (
        output i_tready,
        input  i_tvalid, i_tdata,
        input  o_tready,
        output o_tvalid, o_tdata, o_tkeep, o_tlast, o_err
    );

    modport master (
        input  i_tready,
        output i_tvalid, i_tdata,
        output o_tready,
        input  o_tvalid, o_tdata, o_tkeep, o_tlast, o_err
    );
endinterface

// File: rtl/rx_mass_checker.sv
// Reads a 4-byte little-endian length, checks that many payload bytes against k[7:0], reports
// {timeout, err_cnt} as one 32-bit beat. Optional DATA idle timeout: define RX_MASS_TIMEOUT_EN.
module rx_mass_checker #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd60000000
) (
    input  logic               clk,
    input  logic               rstn,
    rx_mass_checker_if.slave   bus
);
    typedef enum logic [1:0] {LEN, DATA, REPORT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  hdr_cnt;
    logic [31:0] len;
    logic [31:0] byte_cnt;
    logic [30:0] err_cnt;
    logic        to_flag;
    logic        err_q;

    logic        acc;
    logic        hdr_done;
    logic        last_byte;
    logic        mism;
    logic        timeout_hit;
    logic        out_fire;
    logic [31:0] len_nxt;

    assign bus.i_tready = (state != REPORT);
    assign bus.o_tvalid = (state == REPORT);
    assign bus.o_tdata  = {to_flag, err_cnt};
    assign bus.o_tkeep  = 4'hF;
    assign bus.o_tlast  = 1'b1;
    assign bus.o_err    = err_q;

    assign acc       = bus.i_tvalid && bus.i_tready;
    assign out_fire  = bus.o_tvalid && bus.o_tready;
    // Header bytes shift in from the top so the first byte lands in len[7:0] after four accepts.
    assign len_nxt   = {bus.i_tdata, len[31:8]};
    assign hdr_done  = (state == LEN) && acc && (hdr_cnt == 2'd3);
    assign last_byte = (state == DATA) && acc && (byte_cnt == len - 32'd1);
    assign mism      = (state == DATA) && acc && (bus.i_tdata != byte_cnt[7:0]);

`ifdef RX_MASS_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Held at zero outside DATA, so entering DATA starts a fresh idle window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            idle_cnt <= '0;
        else if (state != DATA || acc)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign timeout_hit = (state == DATA) && !acc && (idle_cnt >= TIMEOUT_CYCLES - 32'd1);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= LEN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LEN:     if (hdr_done) state_nxt = (len_nxt == 32'd0) ? REPORT : DATA;
            DATA:    if (last_byte || timeout_hit) state_nxt = REPORT;
            REPORT:  if (out_fire) state_nxt = LEN;
            default: state_nxt = LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_cnt  <= '0;
            len      <= '0;
            byte_cnt <= '0;
            err_cnt  <= '0;
            to_flag  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state == LEN && acc) begin
                len     <= len_nxt;
                hdr_cnt <= hdr_cnt + 2'd1;
            end
            if (hdr_done) begin
                byte_cnt <= '0;
                err_cnt  <= '0;
                to_flag  <= 1'b0;
            end else begin
                if (state == DATA && acc)
                    byte_cnt <= byte_cnt + 32'd1;
                if (mism && err_cnt != 31'h7FFF_FFFF)
                    err_cnt <= err_cnt + 31'd1;
                if (timeout_hit)
                    to_flag <= 1'b1;
            end
            if (out_fire)
                err_q <= (err_cnt != 31'd0) || to_flag;
        end
    end
endmodule

// File: tb/tb_rx_mass_checker.sv
// Randomized scoreboard bench for rx_mass_checker: the stimulus thread predicts each result word
// from the payload it sends, a negedge monitor pops and checks every result handshake.
module tb_rx_mass_checker;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   rdy_mode = 2;
    exp_t sb[$];

    rx_mass_checker_if bus ();

    rx_mass_checker #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, sb=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result-side ready: random, held low, or held high.
    initial begin
        bus.o_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.o_tready = 1'($urandom_range(1));
                1:       bus.o_tready = 1'b0;
                default: bus.o_tready = 1'b1;
            endcase
        end
    end

    // Monitor: o_err is checked one cycle after the handshake it reflects.
    initial begin
        exp_t e;
        bit   err_chk = 0;
        logic err_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                err_chk = 0;
                continue;
            end
            if (err_chk) begin
                check("o_err", 32'(bus.o_err), 32'(err_exp));
                err_chk = 0;
            end
            if (bus.o_tvalid && bus.o_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", bus.o_tdata, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    check("o_tdata", bus.o_tdata, e.data);
                    check("o_tkeep", 32'(bus.o_tkeep), 32'hF);
                    check("o_tlast", 32'(bus.o_tlast), 32'h1);
                    err_exp = e.err;
                    err_chk = 1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        bit ok;
        if (gap && $urandom_range(3) == 0) begin
            bus.i_tvalid = 1'b0;
            repeat ($urandom_range(3, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = b;
        n = 0;
        forever begin
            ok = bus.i_tready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 3000) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout: byte %h not accepted, i_tready=%b expected 1", b, bus.i_tready);
                break;
            end
        end
        bus.i_tvalid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] len, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap);
    endtask

    // Build a payload (optionally corrupting positions bad_a/bad_b or random bytes), predict, send.
    task automatic send_pkt(input int len, input int bad_a, input int bad_b, input bit rnd_bad,
                            input bit gap, input bit hold_last);
        logic [7:0] pl[$];
        logic [7:0] v;
        int   errs;
        exp_t e;
        errs = 0;
        for (int k = 0; k < len; k++) begin
            v = 8'(k % 256);
            if (k == bad_a || k == bad_b || (rnd_bad && $urandom_range(7) == 0))
                v = v ^ 8'($urandom_range(255, 1));
            pl.push_back(v);
        end
        for (int k = 0; k < len; k++) if (int'(pl[k]) != k % 256) errs++;
        e.data = {1'b0, 31'(errs)};
        e.err  = (errs != 0);
        if (!hold_last) sb.push_back(e);
        send_hdr(32'(len), gap);
        foreach (pl[k]) send_byte(pl[k], gap);
        if (hold_last) sb.push_back(e);
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_o_tvalid"}, 32'(bus.o_tvalid), 32'h0);
        check({tag, "_o_tdata"},  bus.o_tdata,       32'h0);
        check({tag, "_o_err"},    32'(bus.o_err),    32'h0);
        check({tag, "_i_tready"}, 32'(bus.i_tready), 32'h1);
        check({tag, "_o_tkeep"},  32'(bus.o_tkeep),  32'hF);
        check({tag, "_o_tlast"},  32'(bus.o_tlast),  32'h1);
    endtask

    initial begin
        exp_t e;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed: len=4 clean, len=0, len=300 with bytes 10 and 299 corrupted.
        send_pkt(4, -1, -1, 0, 0, 0);
        send_pkt(0, -1, -1, 0, 0, 0);
        send_pkt(3, -1, -1, 0, 1, 0);
        send_pkt(300, 10, 299, 0, 0, 0);
        wait_sb_empty();

        // Random packets under random ready and valid gaps.
        rdy_mode = 0;
        for (int p = 0; p < 12; p++)
            send_pkt(int'($urandom_range(40)), -1, -1, 1, 1, 0);
        wait_sb_empty();

        // Result held off for 20 clks while the next header byte waits on the RX side.
        rdy_mode = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_pkt(3, 1, -1, 0, 0, 1);
        e = sb[sb.size() - 1];
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = 8'h05;
        for (int c = 0; c < 20; c++) begin
            check("stall_i_tready", 32'(bus.i_tready), 32'h0);
            check("stall_o_tvalid", 32'(bus.o_tvalid), 32'h1);
            check("stall_o_tdata",  bus.o_tdata,       e.data);
            @(posedge clk);
            #1;
        end
        rdy_mode = 2;
        e.data = 32'h0;
        e.err  = 1'b0;
        sb.push_back(e);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 5; k++) send_byte(8'(k), 0);
        wait_sb_empty();

        // Reset mid-payload, then a fresh len=2 packet must come back clean.
        rdy_mode = 0;
        send_pkt(1, 0, -1, 0, 0, 0);
        wait_sb_empty();
        send_hdr(32'd10, 1);
        for (int k = 0; k < 5; k++) send_byte(8'(k), 1);
        #2;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(2, -1, -1, 0, 1, 0);
        wait_sb_empty();

`ifdef RX_MASS_TIMEOUT_EN
        // Stall mid-payload long enough to trip the idle timeout.
        e.data = 32'h8000_0000;
        e.err  = 1'b1;
        sb.push_back(e);
        send_hdr(32'd8, 0);
        for (int k = 0; k < 3; k++) send_byte(8'(k), 0);
        wait_sb_empty();
        send_pkt(2, -1, -1, 0, 0, 0);
        wait_sb_empty();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
